// File: rtl/cdown_timer.sv
// Programmable countdown timer: reload register, tick prescaler, one-shot or
// periodic operation and a single-cycle terminal-count pulse.
module cdown_timer #(
    parameter int unsigned WID = 8,
    parameter int unsigned DIV = 1
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           load,
    input  logic [WID-1:0] load_val,
    input  logic           start,
    input  logic           stop,
    input  logic           periodic,
    input  logic           tick,
    output logic [WID-1:0] count,
    output logic           busy,
    output logic           tc
);

    localparam int unsigned PW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(DIV - 1);

    typedef enum logic [0:0] {
        StIdle,
        StRun
    } state_e;

    state_e         state_q, state_d;
    logic [WID-1:0] count_q, count_d;
    logic [WID-1:0] reload_q, reload_d;
    logic [PW-1:0]  pre_q, pre_d;
    logic           tc_q, tc_d;
    logic           dec;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= StIdle;
            count_q  <= '0;
            reload_q <= '0;
            pre_q    <= '0;
            tc_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            reload_q <= reload_d;
            pre_q    <= pre_d;
            tc_q     <= tc_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        reload_d = reload_q;
        pre_d    = pre_q;
        tc_d     = 1'b0;
        dec      = 1'b0;

        if (load) begin
            reload_d = load_val;
            count_d  = load_val;
            pre_d    = '0;
        end else if (stop) begin
            if (state_q == StRun) begin
                state_d = StIdle;
                pre_d   = '0;
            end
        end else if (start && (state_q == StIdle)) begin
            // A tick arriving with start is dropped: counting begins next cycle.
            state_d = StRun;
            pre_d   = '0;
        end else if ((state_q == StRun) && tick) begin
            if (pre_q == PRE_LAST) begin
                pre_d = '0;
                dec   = 1'b1;
            end else begin
                pre_d = pre_q + 1'b1;
            end
        end

        // A count of 0 expires like a count of 1, so the counter never wraps.
        if (dec) begin
            if (count_q > WID'(1)) begin
                count_d = count_q - 1'b1;
            end else begin
                tc_d = 1'b1;
                if (periodic) begin
                    count_d = reload_q;
                end else begin
                    count_d = '0;
                    state_d = StIdle;
                end
            end
        end
    end

    assign count = count_q;
    assign busy  = (state_q == StRun);
    assign tc    = tc_q;

endmodule

// File: doc/cdown_timer.md
Name: cdown_timer

Overview:
- Programmable countdown timer with reload register, optional tick prescaler and single-cycle terminal-count pulse.
- Counts downward from a loaded value and is the down-counting counterpart to the clearable up-counter used across the design.
- Used for Game Boy timing functions: serial bit timing, DMA pacing and one-shot delays.
- Operates in one-shot or periodic (auto-reload) mode.

Parameters:
- WID, 8, width of count value and reload register.
- DIV, 1, number of qualified tick strobes per decrement (1..2^16). The prescaler counter width is $clog2(DIV), minimum 1.

Ports:
- clk  input  1  system clock.
- reset  input  1  reset, synchronous, active-high.
- load  input  1  write load_val into reload register and count.
- load_val  input  WID  value written on load.
- start  input  1  begin counting (idle to busy).
- stop  input  1  halt counting; count held.
- periodic  input  1  1 = auto-reload on terminal count, 0 = one-shot. Sampled at the terminal event.
- tick  input  1  count-enable strobe, typically from a divider.
- count  output  WID  current count value (registered).
- busy  output  1  timer running.
- tc  output  1  terminal-count pulse, exactly one cycle wide.

Behaviour:
- States: IDLE (busy=0), RUN (busy=1). busy is the state bit.
- Reset values: count=0, reload=0, busy=0, tc=0, prescaler=0.
- Priority per clock edge: reset > load > stop > start > tick. Only the highest-priority active event takes effect, except where noted below.
- load:
  - reload<=load_val; count<=load_val; prescaler<=0; tc<=0.
  - busy is unchanged, so loading while RUN restarts the countdown from the new value.
- stop:
  - busy<=0; count and reload held; prescaler<=0.
  - stop in IDLE has no effect.
- start:
  - In IDLE: busy<=1, prescaler<=0, count unchanged.
  - In RUN: ignored. The prescaler is not cleared.
- tick handling:
  - Acts only when busy=1 at the start of the cycle and no higher-priority event is active.
  - A tick coincident with start in IDLE is dropped.
  - Each accepted tick increments the prescaler. On the DIV-th accepted tick the prescaler wraps to 0 and a decrement event occurs.
  - With DIV=1, every accepted tick is a decrement event.
- Decrement event:
  - If count > 1: count<=count-1.
  - If count == 1 or count == 0: terminal event. A value of 0 is treated as 1, so it expires on the first decrement event.
- Terminal event:
  - tc<=1 on the following edge, i.e. tc is high during the cycle after the edge that consumed the terminal tick.
  - If periodic=1: count<=reload, busy stays 1. With reload=0, tc fires on every decrement event.
  - If periodic=0: count<=0, busy<=0.
- tc is 0 in every cycle not directly following a terminal event. There is no back-to-back stretching beyond consecutive terminal events.
- Period in periodic mode: reload×DIV accepted ticks between tc pulses, with reload=0 counted as 1.
- Latency: count updates on the edge at which the tick is sampled. tc appears at the same edge as the count reload/zero.
- Arithmetic is unsigned modulo 2^WID. No underflow past 0 is ever produced.
- Reset mid-run: all state returns to reset values the next edge. A pending tc is cleared.
- load coincident with the terminal tick: load wins, no tc, count=load_val.
- stop coincident with the terminal tick: stop wins, no tc, count held at 1.

Test Plan:
- Reset then load_val=3, load, start; tick every cycle, DIV=1, periodic=0 -> count 3,2,1 then 0. tc high one cycle at the count=0 edge; busy falls the same edge.
- periodic=1, reload=4, DIV=1, continuous tick -> tc every 4 cycles. count sequence 4,3,2,1,4,3,...; busy stays 1.
- DIV=4 build, reload=2, tick every cycle -> count decrements every 4 ticks; first tc after 8 accepted ticks.
- Running at count=5: assert stop with tick -> count stays 5, busy=0. Later start plus continued ticks -> resumes 4,3,...; tick in the start cycle is dropped.
- load_val=0, start, periodic=0, one tick -> tc pulse next edge, count=0, busy=0. Same case with periodic=1 -> tc on every tick.
- Simultaneous events:
  - load(9) with the terminal tick -> no tc, count=9.
  - reset asserted while tc would fire -> tc=0, count=0, busy=0.
